// File: rtl/uart_pkg.sv
// Shared definitions for the 32-bit word UART receiver:
// word size in bytes, byte FSM state encoding and default timing constants.
package uart_pkg;

  localparam int BYTES_PER_WORD         = 4;
  localparam int DEFAULT_CLKS_PER_BIT   = 868;    // 100 MHz / 115200
  localparam int DEFAULT_TIMEOUT_CYCLES = 34720;  // about 40 bit times

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/word_32bit_uart_rx_if.sv
// Output bundle of the word receiver.
// The master modport is the receiver; the slave modport is the word consumer.
interface word_32bit_uart_rx_if;

  logic [31:0] word;
  logic        word_valid;
  logic        frame_error;
  logic        timeout_err;
  logic        rx_busy;

  modport master (
    output word, word_valid, frame_error, timeout_err, rx_busy
  );

  modport slave (
    input word, word_valid, frame_error, timeout_err, rx_busy
  );

endinterface

// File: rtl/uart_sm_rx.sv
// 8N1 byte receiver: rx synchroniser, byte FSM, mid-bit sampling and stop check.
// byte_done and frame_err are combinational strobes, high during the cycle
// in which the stop bit is sampled. byte_data stays valid during that cycle.
//
// state | meaning
// IDLE  | line idle; waits for a low level (or for high again after a break)
// START | counts half a bit, then confirms the start bit is still low
// DATA  | samples 8 data bits, one bit time apart, LSB first
// STOP  | samples the stop bit one bit time after the last data bit
module uart_sm_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_done,
  output logic [7:0] byte_data,
  output logic       frame_err,
  output logic       busy
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  logic          rx_meta_q, rx_sync_q;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          wait_high_q, wait_high_d;

  // Two-flop synchroniser; idle-high reset value avoids a false start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // FSM and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      wait_high_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      wait_high_q <= wait_high_d;
    end
  end

  // Next-state logic, bit sampling and stop-bit strobes.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    wait_high_d = wait_high_q;
    byte_done   = 1'b0;
    frame_err   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // After a framing error a held-low line is a break, not a new start bit.
        if (wait_high_q) begin
          if (rx_sync_q) wait_high_d = 1'b0;
        end else if (!rx_sync_q) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (rx_sync_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_DATA;
            bit_idx_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = ST_STOP;
          else                   bit_idx_d = bit_idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          if (rx_sync_q) begin
            byte_done = 1'b1;
          end else begin
            frame_err   = 1'b1;
            wait_high_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign byte_data = shift_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: rtl/word_32bit_uart_rx.sv
// 32-bit word UART receiver: four 8N1 bytes, least significant byte first,
// assembled into one word and announced with a one-cycle word_valid pulse.
// Optional macro WORD_RX_TIMEOUT_EN adds an inter-byte gap timer that aborts
// a partial word; without it timeout_err is tied low and a partial word
// waits indefinitely.
module word_32bit_uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT   = DEFAULT_CLKS_PER_BIT,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  word_32bit_uart_rx_if.master  rx_if
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic        sm_byte_done;
  logic [7:0]  sm_byte_data;
  logic        sm_frame_err;
  logic        sm_busy;
  logic        timeout_hit;

  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] shadow_q, shadow_d;
  logic [31:0] word_q, word_d;
  logic        word_valid_q, word_valid_d;
  logic        frame_error_q, frame_error_d;
  logic        timeout_err_q, timeout_err_d;

  uart_sm_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_sm (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .byte_done (sm_byte_done),
    .byte_data (sm_byte_data),
    .frame_err (sm_frame_err),
    .busy      (sm_busy)
  );

`ifdef WORD_RX_TIMEOUT_EN
  localparam int            GW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [GW-1:0] GAP_LOAD = GW'(TIMEOUT_CYCLES - 1);

  logic [GW-1:0] gap_q, gap_d;

  // Gap down-counter: runs only while a partial word waits between frames.
  always_comb begin
    gap_d       = GAP_LOAD;
    timeout_hit = 1'b0;
    if (!sm_busy && (byte_cnt_q != 2'd0)) begin
      if (gap_q == '0) timeout_hit = 1'b1;
      else             gap_d = gap_q - 1'b1;
    end
  end

  // Gap counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) gap_q <= GAP_LOAD;
    else        gap_q <= gap_d;
  end
`else
  wire unused_timeout_cycles = (TIMEOUT_CYCLES > 0);
  assign timeout_hit = 1'b0;
`endif

  // Word assembly; a framing error or timeout drops the partial word.
  always_comb begin
    byte_cnt_d    = byte_cnt_q;
    shadow_d      = shadow_q;
    word_d        = word_q;
    word_valid_d  = 1'b0;
    frame_error_d = 1'b0;
    timeout_err_d = 1'b0;
    if (sm_frame_err) begin
      frame_error_d = 1'b1;
      byte_cnt_d    = 2'd0;
      shadow_d      = '0;
    end else if (sm_byte_done) begin
      if (byte_cnt_q == LAST_BYTE) begin
        word_d       = {sm_byte_data, shadow_q};
        word_valid_d = 1'b1;
        byte_cnt_d   = 2'd0;
        shadow_d     = '0;
      end else begin
        case (byte_cnt_q)
          2'd0:    shadow_d[7:0]   = sm_byte_data;
          2'd1:    shadow_d[15:8]  = sm_byte_data;
          default: shadow_d[23:16] = sm_byte_data;
        endcase
        byte_cnt_d = byte_cnt_q + 2'd1;
      end
    end else if (timeout_hit) begin
      timeout_err_d = 1'b1;
      byte_cnt_d    = 2'd0;
      shadow_d      = '0;
    end
  end

  // Output and assembly registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_cnt_q    <= 2'd0;
      shadow_q      <= '0;
      word_q        <= '0;
      word_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      byte_cnt_q    <= byte_cnt_d;
      shadow_q      <= shadow_d;
      word_q        <= word_d;
      word_valid_q  <= word_valid_d;
      frame_error_q <= frame_error_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign rx_if.word        = word_q;
  assign rx_if.word_valid  = word_valid_q;
  assign rx_if.frame_error = frame_error_q;
  assign rx_if.timeout_err = timeout_err_q;
  assign rx_if.rx_busy     = sm_busy | (byte_cnt_q != 2'd0);

endmodule

// File: tb/tb_word_32bit_uart_rx.sv
// Testbench for word_32bit_uart_rx with CLKS_PER_BIT=16, TIMEOUT_CYCLES=1000.
// Expected words come from a byte-queue model of the line protocol.
module tb_word_32bit_uart_rx;

  localparam int CPB = 16;
  localparam int TO  = 1000;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic rx    = 1'b1;

  word_32bit_uart_rx_if dut_if ();

  word_32bit_uart_rx #(
    .CLKS_PER_BIT   (CPB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .rx_if (dut_if)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: bytes received so far in the current word, and words expected.
  logic [7:0]  part_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  // Output monitor.
  int          valid_cnt = 0, ferr_cnt = 0, to_cnt = 0, mon_err = 0;
  int          last_valid_cyc = 0, stop_start_cyc = 0;
  logic        prev_valid = 1'b0, prev_ferr = 1'b0, prev_to = 1'b0, prev_rst = 1'b0;
  logic [31:0] prev_word = '0;

  always @(negedge clk) begin
    if (dut_if.word_valid === 1'b1) begin
      valid_cnt++;
      got_q.push_back(dut_if.word);
      last_valid_cyc = cyc;
      if (prev_valid || dut_if.frame_error === 1'b1) mon_err++;
    end
    if (dut_if.frame_error === 1'b1) begin
      ferr_cnt++;
      if (prev_ferr) mon_err++;
    end
    if (dut_if.timeout_err === 1'b1) begin
      to_cnt++;
      if (prev_to) mon_err++;
    end
    if (reset && prev_rst && dut_if.word_valid !== 1'b1 && dut_if.word !== prev_word) mon_err++;
    prev_valid = (dut_if.word_valid === 1'b1);
    prev_ferr  = (dut_if.frame_error === 1'b1);
    prev_to    = (dut_if.timeout_err === 1'b1);
    prev_word  = dut_if.word;
    prev_rst   = reset;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One 8N1 frame; a low stop bit is held low for hold extra cycles, then one idle bit.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int hold);
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(CPB);
    end
    stop_start_cyc = cyc;
    rx = stop_bit;
    idle(CPB);
    if (!stop_bit) begin
      idle(hold);
      rx = 1'b1;
      idle(CPB);
    end
    rx = 1'b1;
    if (stop_bit) begin
      part_q.push_back(b);
      if (part_q.size() == 4) begin
        exp_q.push_back({part_q[3], part_q[2], part_q[1], part_q[0]});
        part_q.delete();
      end
    end else begin
      part_q.delete();
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    idle(3);
    @(posedge clk);
    #2 reset = 1'b1;
    idle(3);
    part_q.delete();
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    idle(3);
    tests_run++;
    if (dut_if.word !== 32'h0) begin tests_failed++; $display("FAIL reset_word got=%h exp=%h", dut_if.word, 32'h0); end
    tests_run++;
    if (dut_if.word_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_word_valid got=%b exp=0", dut_if.word_valid); end
    tests_run++;
    if (dut_if.frame_error !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_error got=%b exp=0", dut_if.frame_error); end
    tests_run++;
    if (dut_if.timeout_err !== 1'b0) begin tests_failed++; $display("FAIL reset_timeout_err got=%b exp=0", dut_if.timeout_err); end
    tests_run++;
    if (dut_if.rx_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_rx_busy got=%b exp=0", dut_if.rx_busy); end
    @(posedge clk);
    #2 reset = 1'b1;
    idle(5);
    tests_run++;
    if (dut_if.rx_busy !== 1'b0 || dut_if.word !== 32'h0) begin
      tests_failed++; $display("FAIL post_reset_idle busy=%b word=%h exp busy=0 word=0", dut_if.rx_busy, dut_if.word);
    end
  endtask

  task automatic test_single_word();
    int base_valid;
    int lat;
    base_valid = valid_cnt;
    send_word(32'hDEADBEEF);
    lat = last_valid_cyc - stop_start_cyc;
    idle(4);
    tests_run++;
    if (valid_cnt - base_valid !== 1) begin tests_failed++; $display("FAIL single_pulses got=%0d exp=1", valid_cnt - base_valid); end
    tests_run++;
    if (dut_if.word !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL single_word got=%h exp=%h", dut_if.word, 32'hDEADBEEF); end
    tests_run++;
    if (lat < 1 || lat > CPB) begin tests_failed++; $display("FAIL single_latency got=%0d exp=1..%0d cycles into stop bit", lat, CPB); end
    tests_run++;
    if (dut_if.rx_busy !== 1'b0) begin tests_failed++; $display("FAIL single_busy_after got=%b exp=0", dut_if.rx_busy); end
  endtask

  task automatic test_back_to_back();
    int base_valid;
    base_valid = valid_cnt;
    got_q.delete();
    send_word(32'h11223344);
    send_word(32'hA5A5A5A5);
    idle(4);
    tests_run++;
    if (valid_cnt - base_valid !== 2 || got_q.size() != 2) begin
      tests_failed++; $display("FAIL b2b_pulses got=%0d exp=2", valid_cnt - base_valid);
    end else begin
      tests_run++;
      if (got_q[0] !== 32'h11223344) begin tests_failed++; $display("FAIL b2b_word0 got=%h exp=%h", got_q[0], 32'h11223344); end
      tests_run++;
      if (got_q[1] !== 32'hA5A5A5A5) begin tests_failed++; $display("FAIL b2b_word1 got=%h exp=%h", got_q[1], 32'hA5A5A5A5); end
    end
  endtask

  task automatic test_frame_error();
    int base_valid, base_ferr;
    base_valid = valid_cnt;
    base_ferr  = ferr_cnt;
    send_byte(8'h11, 1'b1, 0);
    send_byte(8'h22, 1'b0, 3 * CPB);
    tests_run++;
    if (ferr_cnt - base_ferr !== 1) begin tests_failed++; $display("FAIL ferr_pulses got=%0d exp=1", ferr_cnt - base_ferr); end
    tests_run++;
    if (valid_cnt !== base_valid) begin tests_failed++; $display("FAIL ferr_no_valid got=%0d exp=%0d", valid_cnt, base_valid); end
    tests_run++;
    if (dut_if.rx_busy !== 1'b0) begin tests_failed++; $display("FAIL ferr_busy got=%b exp=0", dut_if.rx_busy); end
    send_word(32'h04030201);
    idle(4);
    tests_run++;
    if (valid_cnt - base_valid !== 1) begin tests_failed++; $display("FAIL ferr_recover_pulses got=%0d exp=1", valid_cnt - base_valid); end
    tests_run++;
    if (dut_if.word !== 32'h04030201) begin tests_failed++; $display("FAIL ferr_recover_word got=%h exp=%h", dut_if.word, 32'h04030201); end
  endtask

  task automatic test_glitch();
    int          base_valid, base_ferr;
    logic [31:0] w_before;
    base_valid = valid_cnt;
    base_ferr  = ferr_cnt;
    w_before   = dut_if.word;
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(3 * CPB);
    tests_run++;
    if (ferr_cnt !== base_ferr) begin tests_failed++; $display("FAIL glitch_ferr got=%0d exp=%0d", ferr_cnt, base_ferr); end
    tests_run++;
    if (valid_cnt !== base_valid) begin tests_failed++; $display("FAIL glitch_valid got=%0d exp=%0d", valid_cnt, base_valid); end
    tests_run++;
    if (dut_if.rx_busy !== 1'b0) begin tests_failed++; $display("FAIL glitch_busy got=%b exp=0", dut_if.rx_busy); end
    tests_run++;
    if (dut_if.word !== w_before) begin tests_failed++; $display("FAIL glitch_word got=%h exp=%h", dut_if.word, w_before); end
  endtask

  task automatic test_reset_mid_word();
    send_byte(8'hAA, 1'b1, 0);
    send_byte(8'hBB, 1'b1, 0);
    rx = 1'b0;
    idle(2 * CPB);
    rx = 1'b1;
    do_reset();
    idle(CPB);
    tests_run++;
    if (dut_if.word !== 32'h0 || dut_if.rx_busy !== 1'b0) begin
      tests_failed++; $display("FAIL midreset_state word=%h busy=%b exp word=0 busy=0", dut_if.word, dut_if.rx_busy);
    end
    send_word(32'h12345678);
    idle(4);
    tests_run++;
    if (dut_if.word !== 32'h12345678) begin tests_failed++; $display("FAIL midreset_word got=%h exp=%h", dut_if.word, 32'h12345678); end
  endtask

  task automatic test_timeout();
    int          base_valid, base_to;
    logic [31:0] w_before;
    base_valid = valid_cnt;
    base_to    = to_cnt;
    w_before   = dut_if.word;
    send_byte(8'h0D, 1'b1, 0);
    send_byte(8'hF0, 1'b1, 0);
`ifdef WORD_RX_TIMEOUT_EN
    idle(TO - 20);
    tests_run++;
    if (to_cnt !== base_to) begin tests_failed++; $display("FAIL timeout_early got=%0d exp=%0d", to_cnt, base_to); end
    tests_run++;
    if (dut_if.rx_busy !== 1'b1) begin tests_failed++; $display("FAIL timeout_busy_before got=%b exp=1", dut_if.rx_busy); end
    idle(40);
    tests_run++;
    if (to_cnt - base_to !== 1) begin tests_failed++; $display("FAIL timeout_pulses got=%0d exp=1", to_cnt - base_to); end
    tests_run++;
    if (dut_if.rx_busy !== 1'b0) begin tests_failed++; $display("FAIL timeout_busy_after got=%b exp=0", dut_if.rx_busy); end
    tests_run++;
    if (dut_if.word !== w_before || valid_cnt !== base_valid) begin
      tests_failed++; $display("FAIL timeout_word_untouched got=%h/%0d exp=%h/%0d", dut_if.word, valid_cnt, w_before, base_valid);
    end
    part_q.delete();
    send_word(32'h0BADF00D);
`else
    idle(TO + 200);
    tests_run++;
    if (to_cnt !== base_to) begin tests_failed++; $display("FAIL timeout_disabled got=%0d exp=%0d", to_cnt, base_to); end
    tests_run++;
    if (dut_if.rx_busy !== 1'b1) begin tests_failed++; $display("FAIL partial_held_busy got=%b exp=1", dut_if.rx_busy); end
    tests_run++;
    if (valid_cnt !== base_valid) begin tests_failed++; $display("FAIL partial_no_valid got=%0d exp=%0d", valid_cnt, base_valid); end
    send_byte(8'hAD, 1'b1, 0);
    send_byte(8'h0B, 1'b1, 0);
`endif
    idle(4);
    tests_run++;
    if (valid_cnt - base_valid !== 1) begin tests_failed++; $display("FAIL timeout_next_pulses got=%0d exp=1", valid_cnt - base_valid); end
    tests_run++;
    if (dut_if.word !== 32'h0BADF00D) begin tests_failed++; $display("FAIL timeout_next_word got=%h exp=%h", dut_if.word, 32'h0BADF00D); end
  endtask

  task automatic test_random();
    logic [31:0] w;
    logic        ok;
    do_reset();
    got_q.delete();
    exp_q.delete();
    for (int n = 0; n < 24; n++) begin
      w  = $urandom;
      ok = ($urandom_range(0, 7) != 0);
      send_byte(w[7:0], ok, int'($urandom_range(0, 40)));
      idle(int'($urandom_range(0, 3)) * 5);
    end
    idle(4);
    tests_run++;
    if (got_q.size() != exp_q.size()) begin
      tests_failed++; $display("FAIL random_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests_run++;
      if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL random_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    do_reset();
  endtask

  task automatic test_invariants();
    tests_run++;
    if (mon_err !== 0) begin tests_failed++; $display("FAIL pulse_invariants violations=%0d exp=0", mon_err); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_frame_error();
    test_glitch();
    test_reset_mid_word();
    test_timeout();
    test_random();
    test_invariants();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
